// File: rtl/dense_ctrl.sv
// rtl/dense_ctrl.sv - fully-connected layer sequencer: bias load, MAC over inputs, saturating fixed-point writeback
module dense_ctrl #(
    parameter int IN_COUNT  = 10,
    parameter int OUT_COUNT = 3,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int RELU      = 1,
    localparam int IA = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
    localparam int WA = (IN_COUNT * OUT_COUNT > 1) ? $clog2(IN_COUNT * OUT_COUNT) : 1,
    localparam int OA = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IA-1:0]               bufferIn_adr,
    input  logic signed [DATA_SIZE-1:0] bufferIn_data,
    output logic [WA-1:0]               weightAdr,
    input  logic signed [DATA_SIZE-1:0] weightData,
    output logic [OA-1:0]               biasAdr,
    input  logic signed [DATA_SIZE-1:0] biasData,
    output logic [OA-1:0]               bufferOut_adr,
    output logic [DATA_SIZE-1:0]        bufferOut_data,
    output logic                        bufferOut_wr
);

    localparam int ACCW = 2 * DATA_SIZE + $clog2(IN_COUNT) + 1;

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IA-1:0]            r_i, w_i_nxt;
    logic [OA-1:0]            r_j, w_j_nxt;
    logic [WA-1:0]            r_wbase, w_wbase_nxt;
    logic signed [ACCW-1:0]   r_acc, w_acc_nxt;

    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [ACCW-1:0]        w_prod_ext;
    logic signed [ACCW-1:0]        w_bias_ext;
    logic signed [ACCW-1:0]        w_shift;
    logic [ACCW-DATA_SIZE:0]       w_top;
    logic [DATA_SIZE-1:0]          w_sat;

    assign w_prod     = bufferIn_data * weightData;
    assign w_prod_ext = ACCW'(w_prod);
    assign w_bias_ext = ACCW'(biasData) <<< FRAC_BITS;
    assign w_shift    = r_acc >>> FRAC_BITS;
    assign w_top      = w_shift[ACCW-1:DATA_SIZE-1];

    // Bits above the result sign must all match the sign, otherwise clip to the rail
    always_comb begin
        w_sat = w_shift[DATA_SIZE-1:0];
        if (!w_shift[ACCW-1] && (|w_top)) begin
            w_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (w_shift[ACCW-1] && !(&w_top)) begin
            w_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end
        if ((RELU != 0) && w_sat[DATA_SIZE-1]) begin
            w_sat = '0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_i_nxt        = r_i;
        w_j_nxt        = r_j;
        w_wbase_nxt    = r_wbase;
        w_acc_nxt      = r_acc;
        busy           = 1'b1;
        done           = 1'b0;
        bufferOut_wr   = 1'b0;
        bufferIn_adr   = '0;
        weightAdr      = '0;
        biasAdr        = '0;
        bufferOut_adr  = '0;
        bufferOut_data = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_BIAS;
                    w_j_nxt     = '0;
                    w_wbase_nxt = '0;
                end
            end
            S_BIAS: begin
                biasAdr     = r_j;
                weightAdr   = r_wbase;
                w_i_nxt     = '0;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                // Data for element r_i arrives now; addresses run one element ahead
                w_acc_nxt = (r_i == '0) ? (w_bias_ext + w_prod_ext) : (r_acc + w_prod_ext);
                if (r_i == IA'(IN_COUNT - 1)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_i_nxt      = r_i + 1'b1;
                    bufferIn_adr = r_i + 1'b1;
                    weightAdr    = r_wbase + WA'(r_i) + 1'b1;
                end
            end
            S_WRITE: begin
                bufferOut_wr   = 1'b1;
                bufferOut_adr  = r_j;
                bufferOut_data = w_sat;
                if (r_j == OA'(OUT_COUNT - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_j_nxt     = r_j + 1'b1;
                    w_wbase_nxt = r_wbase + WA'(IN_COUNT);
                    w_state_nxt = S_BIAS;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_wbase <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_wbase <= w_wbase_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_dense_ctrl.sv
// tb/tb_dense_ctrl.sv - self-checking bench for dense_ctrl, RELU and linear instances side by side
module tb_dense_ctrl;

    localparam int IN  = 10;
    localparam int OUT = 3;
    localparam int DS  = 16;
    localparam int FB  = 8;
    localparam int NL  = IN + 2;
    localparam int LAT = OUT * NL + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;

    logic        busy_r, done_r, wr_r, busy_l, done_l, wr_l;
    logic [3:0]  ia_r, ia_l;
    logic [4:0]  wa_r, wa_l;
    logic [1:0]  ba_r, ba_l, oa_r, oa_l;
    logic [15:0] od_r, od_l;
    logic signed [15:0] in_d_r, w_d_r, b_d_r, in_d_l, w_d_l, b_d_l;

    logic signed [15:0] in_mem [IN];
    logic signed [15:0] w_mem  [IN*OUT];
    logic signed [15:0] b_mem  [OUT];

    dense_ctrl #(.IN_COUNT(IN), .OUT_COUNT(OUT), .DATA_SIZE(DS), .FRAC_BITS(FB), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .busy(busy_r), .done(done_r),
        .bufferIn_adr(ia_r), .bufferIn_data(in_d_r), .weightAdr(wa_r), .weightData(w_d_r),
        .biasAdr(ba_r), .biasData(b_d_r), .bufferOut_adr(oa_r), .bufferOut_data(od_r),
        .bufferOut_wr(wr_r));

    dense_ctrl #(.IN_COUNT(IN), .OUT_COUNT(OUT), .DATA_SIZE(DS), .FRAC_BITS(FB), .RELU(0)) u_lin (
        .clk(clk), .rst(rst), .start(start), .busy(busy_l), .done(done_l),
        .bufferIn_adr(ia_l), .bufferIn_data(in_d_l), .weightAdr(wa_l), .weightData(w_d_l),
        .biasAdr(ba_l), .biasData(b_d_l), .bufferOut_adr(oa_l), .bufferOut_data(od_l),
        .bufferOut_wr(wr_l));

    // Synchronous-read RAMs: data follows the address by one cycle
    always @(posedge clk) begin
        in_d_r <= in_mem[ia_r];
        w_d_r  <= w_mem[wa_r];
        b_d_r  <= b_mem[ba_r];
        in_d_l <= in_mem[ia_l];
        w_d_l  <= w_mem[wa_l];
        b_d_l  <= b_mem[ba_l];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input int j, input bit relu);
        longint acc;
        acc = longint'(b_mem[j]) * (longint'(1) << FB);
        for (int i = 0; i < IN; i++) acc += longint'(in_mem[i]) * longint'(w_mem[j*IN+i]);
        acc = acc >>> FB;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return acc[15:0];
    endfunction

    // Timing model: phase counts cycles since the accepted start (1 = first busy cycle)
    int          phase = 0;
    logic [15:0] exp_r [OUT];
    logic [15:0] exp_l [OUT];

    always @(posedge clk) begin
        if (rst) phase <= 0;
        else if (phase == 0) begin
            if (start) begin
                phase <= 1;
                for (int j = 0; j < OUT; j++) begin
                    exp_r[j] <= model(j, 1'b1);
                    exp_l[j] <= model(j, 1'b0);
                end
            end
        end else if (phase == LAT) phase <= 0;
        else phase <= phase + 1;
    end

    bit          chk_en = 1'b0;
    bit          ex_busy, ex_done, ex_wr;
    int          ex_adr;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] cap_r [OUT];
    logic [15:0] cap_l [OUT];

    always @(negedge clk) begin
        if (chk_en) begin
            ex_busy = (phase != 0);
            ex_done = (phase == LAT);
            ex_wr   = (phase != 0) && (phase % NL == 0) && (phase < LAT);
            ex_adr  = phase / NL - 1;
            check("busy_relu", busy_r, ex_busy);
            check("busy_lin",  busy_l, ex_busy);
            check("done_relu", done_r, ex_done);
            check("done_lin",  done_l, ex_done);
            check("wr_relu",   wr_r,   ex_wr);
            check("wr_lin",    wr_l,   ex_wr);
            if (ex_wr) begin
                check("adr_relu",  oa_r, ex_adr);
                check("adr_lin",   oa_l, ex_adr);
                check("data_relu", od_r, exp_r[ex_adr]);
                check("data_lin",  od_l, exp_l[ex_adr]);
            end
            if (wr_r) begin
                wr_cnt <= wr_cnt + 1;
                if (oa_r < OUT) cap_r[oa_r] <= od_r;
            end
            if (wr_l && oa_l < OUT) cap_l[oa_l] <= od_l;
            if (done_r) done_cnt <= done_cnt + 1;
        end
    end

    task automatic fill(input bit ramp, input logic [15:0] iv, input logic [15:0] wv,
                        input logic [15:0] bv0, input logic [15:0] bv1, input logic [15:0] bv2);
        for (int i = 0; i < IN; i++) in_mem[i] = ramp ? 16'(i + 1) : iv;
        for (int k = 0; k < IN*OUT; k++) w_mem[k] = wv;
        b_mem[0] = bv0;
        b_mem[1] = bv1;
        b_mem[2] = bv2;
    endtask

    function automatic logic [15:0] rnd(input int mode);
        logic [15:0] v;
        case (mode)
            0: v = 16'($urandom);
            1: v = 16'($urandom_range(0, 1023)) - 16'd512;
            default: case ($urandom_range(0, 3))
                0: v = 16'h7FFF;
                1: v = 16'h8000;
                2: v = 16'h0000;
                default: v = 16'hFFFF;
            endcase
        endcase
        return v;
    endfunction

    task automatic run_inf(input bit extra, output int n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done_r && n < 200) begin
            start = extra && (n == 5 || n == 20);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] l0, input logic [15:0] l1,
                            input logic [15:0] l2);
        int b, d, n;
        b = wr_cnt;
        d = done_cnt;
        run_inf(1'b0, n);
        @(negedge clk);
        check({tag, " latency"}, n, LAT);
        check({tag, " writes"}, wr_cnt - b, OUT);
        check({tag, " dones"}, done_cnt - d, 1);
        check({tag, " relu0"}, cap_r[0], r0);
        check({tag, " relu1"}, cap_r[1], r1);
        check({tag, " relu2"}, cap_r[2], r2);
        check({tag, " lin0"}, cap_l[0], l0);
        check({tag, " lin1"}, cap_l[1], l1);
        check({tag, " lin2"}, cap_l[2], l2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, d, n, mode;
        rst   = 1'b1;
        start = 1'b0;
        fill(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check("rst busy", busy_r, 1'b0);
        check("rst done", done_r, 1'b0);
        check("rst wr", wr_r, 1'b0);
        check("rst in_adr", ia_r, 0);
        check("rst w_adr", wa_r, 0);
        check("rst b_adr", ba_r, 0);
        check("rst out_adr", oa_r, 0);
        check("rst out_data", od_r, 0);
        check("rst out_data_lin", od_l, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        fill(1'b1, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0);
        directed("unity", 16'h0037, 16'h0037, 16'h0037, 16'h0037, 16'h0037, 16'h0037);
        fill(1'b1, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0);
        directed("neg", 16'h0000, 16'h0000, 16'h0000, 16'hFFC9, 16'hFFC9, 16'hFFC9);
        fill(1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        directed("satpos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        fill(1'b0, 16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0);
        directed("satneg", 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000);
        fill(1'b1, 16'h0, 16'h0, 16'h0200, 16'h0100, 16'h0300);
        directed("bias", 16'h0200, 16'h0100, 16'h0300, 16'h0200, 16'h0100, 16'h0300);

        // Stray starts while busy and in DONE, then a start in the following IDLE cycle
        fill(1'b1, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0);
        b = wr_cnt;
        d = done_cnt;
        run_inf(1'b1, n);
        check("b2b first latency", n, LAT);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b first writes", wr_cnt - b, OUT);
        check("b2b first dones", done_cnt - d, 1);
        n = 0;
        while (!done_r && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b second latency", n, LAT - 1);
        @(negedge clk);
        check("b2b total writes", wr_cnt - b, 2 * OUT);
        check("b2b total dones", done_cnt - d, 2);
        check("b2b data2", cap_l[2], 16'h0037);

        // Abort during the MAC of neuron 1; start asserted alongside rst must lose
        fill(1'b1, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0);
        b = wr_cnt;
        d = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < NL + 4) begin
            @(negedge clk);
            n++;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort busy_relu", busy_r, 1'b0);
        check("abort busy_lin", busy_l, 1'b0);
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst over start busy", busy_r, 1'b0);
        repeat (30) @(negedge clk);
        check("abort writes", wr_cnt - b, 1);
        check("abort dones", done_cnt - d, 0);
        fill(1'b1, 16'h0, 16'h0, 16'h0200, 16'h0100, 16'h0300);
        directed("post_abort", 16'h0200, 16'h0100, 16'h0300, 16'h0200, 16'h0100, 16'h0300);

        for (int t = 0; t < 12; t++) begin
            mode = t % 3;
            for (int i = 0; i < IN; i++) in_mem[i] = rnd(mode);
            for (int k = 0; k < IN*OUT; k++) w_mem[k] = rnd(mode);
            for (int j = 0; j < OUT; j++) b_mem[j] = rnd(mode);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = wr_cnt;
            run_inf(1'b0, n);
            @(negedge clk);
            check("rand latency", n, LAT);
            check("rand writes", wr_cnt - b, OUT);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
